// File: rtl/serv_fetch_buf_pkg.sv
// Shared types for the instruction prefetch buffer: bus FSM state encodings,
// the buffered {pc, word} entry, and word-alignment of fetch addresses.
package serv_fetch_buf_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'b00,
        FETCH_BUSY    = 2'b01,
        FETCH_DISCARD = 2'b10
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rdt;
    } fetch_entry_t;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/serv_fetch_fifo.sv
// Small circular FIFO holding fetched {pc, word} pairs; clear has priority over
// push/pop so a redirect empties it on the same edge.
module serv_fetch_fifo
    import serv_fetch_buf_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_push,
    input  fetch_entry_t  i_data,
    input  logic          i_pop,
    output fetch_entry_t  o_data,
    output logic          o_empty,
    output logic          o_full,
    output logic [CW-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_empty = (count == '0);
    assign o_full  = (count == CW'(DEPTH));
    assign o_count = count;
    assign o_data  = mem[rd_ptr];

    // A push into a full FIFO is only accepted when the head leaves on the same edge.
    assign pop_ok  = i_pop && !o_empty;
    assign push_ok = i_push && (!o_full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n || i_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serv_fetch_buf.sv
// Instruction prefetch stage: issues sequential Wishbone-classic reads, buffers
// the returned words and hands one to the decoder per core request.
module serv_fetch_buf
    import serv_fetch_buf_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_fetch_req,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_en,
    output logic [31:0] o_rdt,
    output logic [31:0] o_pc,
    output logic [31:0] o_ibus_adr,
    output logic        o_ibus_cyc,
    input  logic [31:0] i_ibus_rdt,
    input  logic        i_ibus_ack
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state;
    logic [31:0]   fetch_pc;
    logic          pending;

    fetch_entry_t  push_data;
    fetch_entry_t  head;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;

    logic          in_flight;
    logic          room;
    logic          want;
    logic          serve;
    logic          push;

    // Only a BUSY cycle will deposit a word; a DISCARD cycle is already written off.
    assign in_flight = (state == FETCH_BUSY);
    assign room      = !fifo_full && ((fifo_count + CW'(in_flight)) < CW'(DEPTH));

    assign want  = pending || i_fetch_req;
    assign serve = want && !fifo_empty && !i_redirect;
    assign push  = (state == FETCH_BUSY) && i_ibus_ack && !i_redirect;

    assign push_data.pc  = o_ibus_adr;
    assign push_data.rdt = i_ibus_rdt;

    serv_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_redirect),
        .i_push  (push),
        .i_data  (push_data),
        .i_pop   (serve),
        .o_data  (head),
        .o_empty (fifo_empty),
        .o_full  (fifo_full),
        .o_count (fifo_count)
    );

    // Bus FSM: a classic cycle cannot be aborted, so a redirect mid-cycle waits
    // in DISCARD for the ack; the address stays frozen while cyc is high.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state      <= FETCH_IDLE;
            o_ibus_cyc <= 1'b0;
            o_ibus_adr <= word_align(RESET_PC);
            fetch_pc   <= word_align(RESET_PC);
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (!i_redirect && room) begin
                        state      <= FETCH_BUSY;
                        o_ibus_cyc <= 1'b1;
                        o_ibus_adr <= fetch_pc;
                    end
                end
                FETCH_BUSY: begin
                    if (i_ibus_ack) begin
                        state      <= FETCH_IDLE;
                        o_ibus_cyc <= 1'b0;
                        if (!i_redirect) begin
                            fetch_pc <= o_ibus_adr + 32'd4;
                        end
                    end else if (i_redirect) begin
                        state <= FETCH_DISCARD;
                    end
                end
                FETCH_DISCARD: begin
                    if (i_ibus_ack) begin
                        state      <= FETCH_IDLE;
                        o_ibus_cyc <= 1'b0;
                    end
                end
                default: begin
                    state      <= FETCH_IDLE;
                    o_ibus_cyc <= 1'b0;
                end
            endcase
            if (i_redirect) begin
                fetch_pc <= word_align(i_redirect_pc);
            end
        end
    end

    // Delivery: a request stays pending until a buffered word can be handed over.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            o_en    <= 1'b0;
            o_rdt   <= 32'd0;
            o_pc    <= 32'd0;
            pending <= 1'b0;
        end else begin
            o_en    <= serve;
            pending <= want && !serve;
            if (serve) begin
                o_rdt <= head.rdt;
                o_pc  <= head.pc;
            end
        end
    end

endmodule

// File: tb/tb_serv_fetch_buf.sv
// Directed bench for serv_fetch_buf: a Wishbone responder model, queues of
// expected bus addresses and delivered words, and monitors that check them.
module tb_serv_fetch_buf;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        en;
    logic [31:0] rdt;
    logic [31:0] pc;
    logic [31:0] ibus_adr;
    logic        ibus_cyc;
    logic [31:0] ibus_rdt;
    logic        ibus_ack;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          bus_cnt = 0;
    int          ack_delay = 1;
    int          cyc_cnt = 0;
    logic [31:0] bus_exp [$];
    logic [31:0] dlv_exp [$];
    logic        prev_cyc = 1'b0;
    logic [31:0] prev_adr = 32'd0;

    serv_fetch_buf #(
        .RESET_PC (32'h0000_0100),
        .DEPTH    (2)
    ) dut (
        .clk           (clk),
        .i_rst_n       (rst_n),
        .i_fetch_req   (fetch_req),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_en          (en),
        .o_rdt         (rdt),
        .o_pc          (pc),
        .o_ibus_adr    (ibus_adr),
        .o_ibus_cyc    (ibus_cyc),
        .i_ibus_rdt    (ibus_rdt),
        .i_ibus_ack    (ibus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_req();
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
    endtask

    // mode 0: wait for cyc high, 1: wait for ack high, 2: wait for cyc low
    task automatic wait_sig(input int mode, input int limit, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            step();
            case (mode)
                0:       hit = (ibus_cyc === 1'b1);
                1:       hit = (ibus_ack === 1'b1);
                default: hit = (ibus_cyc === 1'b0);
            endcase
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("[TB] FAIL %s: condition not reached within %0d cycles", name, limit);
        end
    endtask

    // Wishbone slave: ack after ack_delay cycles of cyc, data derived from address
    initial begin
        ibus_ack = 1'b0;
        ibus_rdt = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (ibus_cyc !== 1'b1) begin
                cyc_cnt  = 0;
                ibus_ack = 1'b0;
            end else begin
                cyc_cnt++;
                if (cyc_cnt >= ack_delay + 1) begin
                    ibus_ack = 1'b1;
                    ibus_rdt = mem_word(ibus_adr);
                end else begin
                    ibus_ack = 1'b0;
                end
            end
        end
    end

    // Monitor: bus cycles and delivered words against the expectation queues
    always @(negedge clk) begin
        if (ibus_cyc === 1'b1 && ibus_ack === 1'b1) begin
            bus_cnt++;
            if (bus_exp.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("[TB] FAIL bus_unexpected: got cycle at %h, expected none", ibus_adr);
            end else begin
                check_output("bus_adr", ibus_adr, bus_exp.pop_front());
            end
        end
        if (ibus_cyc === 1'b1 && prev_cyc === 1'b1) begin
            check_output("adr_stable", ibus_adr, prev_adr);
        end
        prev_cyc = ibus_cyc;
        prev_adr = ibus_adr;
        if (en === 1'b1) begin
            if (dlv_exp.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("[TB] FAIL dlv_unexpected: got o_en with pc %h, expected none", pc);
            end else begin
                logic [31:0] e;
                e = dlv_exp.pop_front();
                check_output("dlv_pc", pc, e);
                check_output("dlv_rdt", rdt, mem_word(e));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        fetch_req   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        repeat (3) step();
        @(negedge clk);
        check_output("rst_en", 32'(en), 32'd0);
        check_output("rst_cyc", 32'(ibus_cyc), 32'd0);
        check_output("rst_rdt", rdt, 32'd0);
        check_output("rst_pc", pc, 32'd0);
        check_output("rst_adr", ibus_adr, 32'h0000_0100);

        // Fill after reset, then one request
        bus_exp.push_back(32'h100);
        bus_exp.push_back(32'h104);
        step();
        rst_n = 1'b1;
        repeat (15) step();
        @(negedge clk);
        check_output("fill_cycles", 32'(bus_cnt), 32'd2);
        check_output("full_no_cyc", 32'(ibus_cyc), 32'd0);
        ack_delay = 5;
        dlv_exp.push_back(32'h100);
        bus_exp.push_back(32'h108);
        pulse_req();
        @(negedge clk);
        check_output("req_latency", 32'(en), 32'd1);
        @(negedge clk);
        check_output("en_strobe", 32'(en), 32'd0);
        check_output("pc_hold", pc, 32'h100);
        check_output("rdt_hold", rdt, mem_word(32'h100));

        // Redirect while BUSY at 0x108
        wait_sig(0, 10, "busy_0x108");
        redirect_pc = 32'h0000_2002;
        redirect    = 1'b1;
        bus_exp.push_back(32'h2000);
        bus_exp.push_back(32'h2004);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check_output("discard_hold", 32'(ibus_cyc), 32'd1);
        check_output("discard_adr", ibus_adr, 32'h108);
        wait_sig(2, 20, "discard_ack");
        ack_delay = 1;
        repeat (15) step();
        dlv_exp.push_back(32'h2000);
        bus_exp.push_back(32'h2008);
        pulse_req();
        repeat (10) step();

        // Redirect coinciding with ack
        ack_delay = 3;
        dlv_exp.push_back(32'h2004);
        bus_exp.push_back(32'h200C);
        pulse_req();
        wait_sig(1, 20, "ack_0x200c");
        redirect_pc = 32'h0000_3000;
        redirect    = 1'b1;
        bus_exp.push_back(32'h3000);
        bus_exp.push_back(32'h3004);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check_output("redir_ack_idle", 32'(ibus_cyc), 32'd0);
        ack_delay = 1;
        repeat (15) step();

        // Redirect and request together
        redirect_pc = 32'h0000_4000;
        redirect    = 1'b1;
        fetch_req   = 1'b1;
        dlv_exp.push_back(32'h4000);
        bus_exp.push_back(32'h4000);
        bus_exp.push_back(32'h4004);
        bus_exp.push_back(32'h4008);
        step();
        redirect  = 1'b0;
        fetch_req = 1'b0;
        repeat (20) step();
        check_output("redir_req_drained", 32'(dlv_exp.size()), 32'd0);

        // Stalled ack with a repeated request
        ack_delay   = 10;
        redirect_pc = 32'h0000_5000;
        redirect    = 1'b1;
        bus_exp.push_back(32'h5000);
        bus_exp.push_back(32'h5004);
        bus_exp.push_back(32'h5008);
        dlv_exp.push_back(32'h5000);
        step();
        redirect = 1'b0;
        step();
        pulse_req();
        repeat (3) step();
        pulse_req();
        wait_sig(1, 30, "stall_ack");
        @(posedge clk);
        @(negedge clk);
        check_output("no_bypass", 32'(en), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_output("stall_latency", 32'(en), 32'd1);
        ack_delay = 1;
        repeat (40) step();

        // Address wrap, then reset during a bus cycle
        redirect_pc = 32'hFFFF_FFF8;
        redirect    = 1'b1;
        bus_exp.push_back(32'hFFFF_FFF8);
        bus_exp.push_back(32'hFFFF_FFFC);
        step();
        redirect = 1'b0;
        repeat (15) step();
        dlv_exp.push_back(32'hFFFF_FFF8);
        bus_exp.push_back(32'h0000_0000);
        pulse_req();
        repeat (10) step();
        ack_delay = 10;
        dlv_exp.push_back(32'hFFFF_FFFC);
        pulse_req();
        wait_sig(0, 10, "busy_0x4");
        @(negedge clk);
        check_output("wrap_next_adr", ibus_adr, 32'h0000_0004);
        rst_n = 1'b0;
        step();
        @(negedge clk);
        check_output("rst_drops_cyc", 32'(ibus_cyc), 32'd0);
        check_output("rst_adr2", ibus_adr, 32'h100);
        ack_delay = 1;
        dlv_exp.push_back(32'h100);
        bus_exp.push_back(32'h100);
        bus_exp.push_back(32'h104);
        bus_exp.push_back(32'h108);
        step();
        rst_n     = 1'b1;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        repeat (20) step();
        @(negedge clk);
        check_output("bus_drained", 32'(bus_exp.size()), 32'd0);
        check_output("dlv_drained", 32'(dlv_exp.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
